// File: rtl/fft_addr_gen_if.sv
// Issue bus between the FFT address generator and the butterfly datapath:
// start pulse in, four butterflies' read addresses and twiddle indices out.
interface fft_addr_gen_if;
    logic       go;
    logic [7:0] addr_0;
    logic [7:0] addr_1;
    logic [7:0] addr_2;
    logic [7:0] addr_3;
    logic [7:0] addr_4;
    logic [7:0] addr_5;
    logic [7:0] addr_6;
    logic [7:0] addr_7;
    logic [6:0] tw_idx_0;
    logic [6:0] tw_idx_1;
    logic [6:0] tw_idx_2;
    logic [6:0] tw_idx_3;
    logic       bf_start;
    logic [2:0] stage;
    logic       busy;
    logic       done;

    // master: the address generator; slave: the butterfly-side consumer
    modport master (
        input  go,
        output addr_0, addr_1, addr_2, addr_3, addr_4, addr_5, addr_6, addr_7,
        output tw_idx_0, tw_idx_1, tw_idx_2, tw_idx_3,
        output bf_start, stage, busy, done
    );

    modport slave (
        output go,
        input  addr_0, addr_1, addr_2, addr_3, addr_4, addr_5, addr_6, addr_7,
        input  tw_idx_0, tw_idx_1, tw_idx_2, tw_idx_3,
        input  bf_start, stage, busy, done
    );
endinterface

// File: rtl/fft_addr_gen.sv
// Address/twiddle generator for a 256-point in-place radix-2 DIT FFT that
// issues four butterflies per cycle over 8 stages, with a drain gap per stage.
module fft_addr_gen #(
    parameter int GAP = 4
) (
    input  logic          clk,
    input  logic          rst,
    fft_addr_gen_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    state_t     state_reg, state_next;
    logic [2:0] stage_reg, stage_next;
    logic [4:0] cyc_reg, cyc_next;
    logic [3:0] gap_reg, gap_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            stage_reg <= 3'd0;
            cyc_reg   <= 5'd0;
            gap_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            stage_reg <= stage_next;
            cyc_reg   <= cyc_next;
            gap_reg   <= gap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        cyc_next   = cyc_reg;
        gap_next   = gap_reg;
        case (state_reg)
            ST_IDLE: begin
                stage_next = 3'd0;
                cyc_next   = 5'd0;
                gap_next   = 4'd0;
                if (bus.go) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cyc_next = cyc_reg + 5'd1;
                if (cyc_reg == 5'd31) begin
                    gap_next   = 4'd0;
                    state_next = (stage_reg == 3'd7) ? ST_FLUSH : ST_GAP;
                end
            end
            ST_GAP: begin
                gap_next = gap_reg + 4'd1;
                if (gap_reg == GAP_LAST) begin
                    gap_next   = 4'd0;
                    cyc_next   = 5'd0;
                    stage_next = stage_reg + 3'd1;
                    state_next = ST_ISSUE;
                end
            end
            ST_FLUSH: begin
                gap_next = gap_reg + 4'd1;
                if (gap_reg == GAP_LAST) begin
                    gap_next   = 4'd0;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                stage_next = 3'd0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                stage_next = 3'd0;
                cyc_next   = 5'd0;
                gap_next   = 4'd0;
            end
        endcase
    end

    // Top index is j with a zero inserted at bit s; bottom sets that bit.
    logic [7:0] span;
    logic [7:0] mask;
    logic [7:0] top_w [4];
    logic [7:0] bot_w [4];
    logic [6:0] tw_w  [4];

    assign span = 8'd1 << stage_reg;
    assign mask = span - 8'd1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bf
        logic [6:0] j;
        logic [7:0] j8;
        logic [6:0] pos;

        assign j         = {cyc_reg, 2'(gi)};
        assign j8        = {1'b0, j};
        assign pos       = j & mask[6:0];
        assign top_w[gi] = ((j8 & ~mask) << 1) | (j8 & mask);
        assign bot_w[gi] = top_w[gi] | span;
        assign tw_w[gi]  = pos << (3'd7 - stage_reg);
    end

    logic [7:0] addr_reg [8];
    logic [6:0] tw_reg   [4];
    logic       bf_start_reg;
    logic [2:0] stage_out_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       issue;

    assign issue = (state_reg == ST_ISSUE);

    // Outputs trail the FSM by one cycle so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                addr_reg[2*k]   <= 8'd0;
                addr_reg[2*k+1] <= 8'd0;
                tw_reg[k]       <= 7'd0;
            end
            bf_start_reg  <= 1'b0;
            stage_out_reg <= 3'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                addr_reg[2*k]   <= issue ? top_w[k] : 8'd0;
                addr_reg[2*k+1] <= issue ? bot_w[k] : 8'd0;
                tw_reg[k]       <= issue ? tw_w[k]  : 7'd0;
            end
            bf_start_reg  <= issue;
            stage_out_reg <= stage_reg;
            busy_reg      <= (state_reg != ST_IDLE) && (state_reg != ST_DONE);
            done_reg      <= (state_reg == ST_DONE);
        end
    end

    assign bus.addr_0   = addr_reg[0];
    assign bus.addr_1   = addr_reg[1];
    assign bus.addr_2   = addr_reg[2];
    assign bus.addr_3   = addr_reg[3];
    assign bus.addr_4   = addr_reg[4];
    assign bus.addr_5   = addr_reg[5];
    assign bus.addr_6   = addr_reg[6];
    assign bus.addr_7   = addr_reg[7];
    assign bus.tw_idx_0 = tw_reg[0];
    assign bus.tw_idx_1 = tw_reg[1];
    assign bus.tw_idx_2 = tw_reg[2];
    assign bus.tw_idx_3 = tw_reg[3];
    assign bus.bf_start = bf_start_reg;
    assign bus.stage    = stage_out_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;

endmodule

// File: doc/fft_addr_gen.md
# fft_addr_gen

Control and address-generation stage that sits directly upstream of the 4-wide butterfly stage in the 256-point radix-2 DIT FFT. On a `go` pulse it walks all 8 stages of an in-place transform over bit-reversed input memory. Each cycle it issues 4 butterflies: eight 8-bit read addresses, four 7-bit twiddle ROM indices and a `bf_start` strobe. The read data, the twiddle lookup and the butterfly stage consume these outputs. Between stages it inserts a fixed gap so the 3-cycle butterfly pipeline and write-back drain before dependent reads.

## Interface
- `GAP`, 4, idle cycles inserted after each stage's last issue cycle (pipeline plus write-back latency); legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  start pulse; sampled only in IDLE.
- `addr_0`..`addr_7`  out  8 each  read addresses. `addr_{2k}` is the top operand of butterfly k; `addr_{2k+1}` is the bottom operand of butterfly k (k = 0..3).
- `tw_idx_0`..`tw_idx_3`  out  7 each  twiddle index n for butterfly k, meaning W_256^n.
- `bf_start`  out  1  high when the address and twiddle outputs are a valid issue.
- `stage`  out  3  current stage 0..7.
- `busy`  out  1  high from the cycle after `go` is accepted through the cycle before `done`.
- `done`  out  1  one-cycle pulse after the final flush.

## Operation
- FSM states: IDLE, ISSUE, GAP, FLUSH, DONE.
  - IDLE, `go`=1: go to ISSUE, with stage=0 and cycle counter c=0.
  - ISSUE: runs 32 cycles (c = 0..31). At c=31, go to GAP if stage<7, else go to FLUSH.
  - GAP: runs `GAP` cycles, then go to ISSUE with stage+1 and c=0.
  - FLUSH: runs `GAP` cycles, then go to DONE.
  - DONE: lasts 1 cycle, then go to IDLE.
- Butterfly numbering within a cycle: j = 4c + k, for k = 0..3 and j = 0..127.
- Address and twiddle arithmetic for stage s:
  - span = 1<<s
  - pos = j & (span-1)
  - grp = j >> s
  - top = (grp << (s+1)) | pos, computed modulo 256
  - bottom = top + span
  - tw = pos << (7-s), 7 bits
- All outputs are registered. The address and twiddle values are valid in the same cycle that `bf_start`=1.
- Outside ISSUE, `bf_start`=0 and the address and twiddle outputs hold 0.
- `go` is ignored in every state except IDLE, including the DONE cycle.
- `rst` takes priority over all other inputs at any time, including mid-stage. Reset returns the FSM to IDLE with every output 0 on the next edge, and no further `bf_start` is issued.
- `stage` holds its value through GAP and FLUSH, and returns to 0 in IDLE.

## Timing
- Reset values: all addresses 0, all `tw_idx` 0, `bf_start` 0, `stage` 0, `busy` 0, `done` 0.
- Take `go` sampled high at edge 0. Then:
  - first `bf_start` appears at cycle 1;
  - stage s issues during cycles 1 + s·(32+GAP) through 1 + s·(32+GAP) + 31;
  - `done` is high at cycle 1 + 8·(32+GAP), which is 289 for GAP=4.
- Total issues per run: 256 cycles with `bf_start`=1 (1024 butterflies).
- A `go` held high continuously starts a new run on the cycle after DONE, because that cycle is IDLE.

## Test plan
- Reset, then stage 0, c=0:
  - stimulus: hold `rst` for 2 cycles, then pulse `go`.
  - required at cycle 1: `bf_start`=1, addresses 0..7 = {0,1,2,3,4,5,6,7}, all `tw_idx`=0.
- Stage 2, c=1:
  - required addresses (top, bottom) = (8,12) (9,13) (10,14) (11,15).
  - required `tw_idx` = {0,32,64,96}.
- Stage 7, first and last issue cycles:
  - c=0: tops 0..3, bottoms 128..131, `tw_idx` 0..3.
  - c=31: tops 124..127, bottoms 252..255, `tw_idx` 124..127.
- Full run with GAP=4:
  - count exactly 256 `bf_start` cycles.
  - every address 0..255 appears exactly once per stage.
  - `bf_start`=0 for 4 cycles between stages.
  - `done` pulses once, at cycle 289.
  - `busy` is high from cycle 1 through cycle 288.
- Reset mid-run:
  - stimulus: assert `rst` during stage 3, c=10.
  - required: all outputs are 0 on the next cycle and stay in IDLE.
  - a following `go` restarts at stage 0, c=0.
- `go` pulses during ISSUE, GAP and DONE:
  - required: all are ignored, `done` pulses exactly once, and no stage restarts.
